gate_bist: RTL and testbench

Built-in self-test sequencer for small combinational gates such as nand_gate. It drives every input combination onto a gate under test and waits a programmable settle time before sampling each output. Each sample is compared against a truth-table parameter, and the block reports pass/fail, an error count and the first failing vector. It is the hardware counterpart of the per-gate simulation benches and sits beside a gate instance on the FPGA, with results routed to LEDs or a debug port.

---
 rtl/gate_bist_pkg.sv | 21 ++
 rtl/gate_bist_settle_timer.sv | 42 ++++
 rtl/gate_bist.sv | 123 ++++++++++++
 tb/tb_gate_bist.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate BIST sequencer: FSM encodings, common
// two-input truth tables and a width helper for the settle counter.
package gate_bist_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bit i is the expected output for input vector i (a = MSB).
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

  // Counter width able to hold 0 .. settle-1 (at least one bit).
  function automatic int unsigned settle_cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Settle-time counter: counts cycles a vector has been driven and flags the
// last DRIVE cycle (count == SETTLE-1).
module gate_bist_settle_timer
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = settle_cnt_width(SETTLE);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Clear wins over count; counting stops at LAST so the value never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test sequencer for a small combinational gate. Sweeps every
// input vector, holds each for SETTLE cycles, samples the gate output once
// and compares it with the TRUTH table, accumulating pass/fail results.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned              N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]     TRUTH  = 4'b0111,
  parameter int unsigned              SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;

  logic timer_clear;
  logic timer_en;
  logic expired;
  logic mismatch;

  gate_bist_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  // FSM, vector stepping and result accumulation.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    err_d       = err_q;
    ff_d        = ff_q;
    ffv_d       = ffv_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    mismatch    = (dut_out != TRUTH[vec_q]);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start in DONE clears the previous results exactly like IDLE.
        if (start) begin
          state_d     = ST_DRIVE;
          vec_d       = '0;
          err_d       = '0;
          ff_d        = '0;
          ffv_d       = 1'b0;
          timer_clear = 1'b1;
        end
      end
      ST_DRIVE: begin
        timer_en = 1'b1;
        if (expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d       = vec_q + VEC_ONE;
          timer_clear = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign dut_in           = vec_q;
  assign busy             = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: a timeline-based reference model is
// compared against the DUT on every cycle, plus literal checks for the
// directed scenarios and a second 3-input instance.
module tb_gate_bist;

  localparam int          SETTLE = 2;
  localparam int          NV     = 4;
  localparam logic [3:0]  TRUTH  = 4'b0111;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_fail;
  logic       first_fail_valid;

  // Emulated gate under test: its truth table is a bench variable.
  logic [3:0] gate_tt;
  assign dut_out = gate_tt[dut_in];

  logic       start3;
  logic [2:0] din3;
  logic       out3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] ff3;
  logic       ffv3;
  assign out3 = ~&din3;

  always #5 clk = ~clk;

  gate_bist #(
    .N_IN   (2),
    .TRUTH  (TRUTH),
    .SETTLE (SETTLE)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .dut_in           (dut_in),
    .dut_out          (dut_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail       (first_fail),
    .first_fail_valid (first_fail_valid)
  );

  gate_bist #(
    .N_IN   (3),
    .TRUTH  (8'h7F),
    .SETTLE (1)
  ) u_dut3 (
    .clk              (clk),
    .rst              (rst),
    .start            (start3),
    .dut_in           (din3),
    .dut_out          (out3),
    .busy             (busy3),
    .done             (done3),
    .pass             (pass3),
    .err_count        (err3),
    .first_fail       (ff3),
    .first_fail_valid (ffv3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: a sweep is a timeline t = cycles since the accepting
  // edge; vector t/(SETTLE+1) is driven and sampled when t%(SETTLE+1)==SETTLE.
  bit m_act, m_done, m_ffv;
  int m_t, m_err, m_ff, m_din, m_k;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_t = 0; m_err = 0; m_ff = 0; m_ffv = 0; m_din = 0;
    end else if (start && !m_act) begin
      m_act = 1; m_done = 0; m_t = 0; m_err = 0; m_ff = 0; m_ffv = 0; m_din = 0;
    end else if (m_act) begin
      if (m_t % (SETTLE + 1) == SETTLE) begin
        m_k = m_t / (SETTLE + 1);
        if (gate_tt[m_k] != TRUTH[m_k]) begin
          m_err++;
          if (!m_ffv) begin
            m_ff  = m_k;
            m_ffv = 1;
          end
        end
        if (m_k == NV - 1) begin
          m_act  = 0;
          m_done = 1;
        end
      end
      m_t++;
      if (m_act) m_din = m_t / (SETTLE + 1);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("pass", {31'd0, pass}, {31'd0, (m_done && m_err == 0)});
      chk("err_count", {29'd0, err_count}, m_err);
      chk("first_fail_valid", {31'd0, first_fail_valid}, {31'd0, m_ffv});
      chk("first_fail", {30'd0, first_fail}, m_ff);
      chk("dut_in", {30'd0, dut_in}, m_din);
      if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until done (bounded).
  int din_at4;
  task automatic run_sweep(input logic [3:0] tt, output int cyc);
    gate_tt = tt;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 0;
    din_at4 = -1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 4) din_at4 = dut_in;
    end
    if (!done) chk("sweep_timeout", 32'd0, 32'd1);
  endtask

  int cyc;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    start3  = 1'b0;
    gate_tt = 4'b0111;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dut_in", {30'd0, dut_in}, 32'd0);
    rst = 1'b0;
    tick();

    // NAND gate: clean pass, 12-cycle latency, vector 1 driven at cycle 4.
    run_sweep(4'b0111, cyc);
    chk("nand_latency", cyc, 12);
    chk("nand_pass", {31'd0, pass}, 32'd1);
    chk("nand_err", {29'd0, err_count}, 32'd0);
    chk("nand_ffv", {31'd0, first_fail_valid}, 32'd0);
    chk("nand_din_step", din_at4, 1);

    // AND gate: every vector wrong.
    run_sweep(4'b1000, cyc);
    chk("and_err", {29'd0, err_count}, 32'd4);
    chk("and_ff", {30'd0, first_fail}, 32'd0);
    chk("and_ffv", {31'd0, first_fail_valid}, 32'd1);
    chk("and_pass", {31'd0, pass}, 32'd0);

    // Output tied high: only vector 3 fails.
    run_sweep(4'b1111, cyc);
    chk("tie1_err", {29'd0, err_count}, 32'd1);
    chk("tie1_ff", {30'd0, first_fail}, 32'd3);
    chk("tie1_pass", {31'd0, pass}, 32'd0);

    // Reset five cycles into a sweep, then a clean sweep.
    gate_tt = 4'b1000;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_err", {29'd0, err_count}, 32'd0);
    chk("abort_ffv", {31'd0, first_fail_valid}, 32'd0);
    rst = 1'b0;
    run_sweep(4'b0111, cyc);
    chk("after_abort_latency", cyc, 12);
    chk("after_abort_pass", {31'd0, pass}, 32'd1);

    // start held high: no restart until DONE, then restart clears results.
    gate_tt = 4'b1111;
    start   = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("held_latency", cyc, 12);
    chk("held_err", {29'd0, err_count}, 32'd1);
    tick();
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_err", {29'd0, err_count}, 32'd0);
    chk("restart_ffv", {31'd0, first_fail_valid}, 32'd0);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("restart_done", {31'd0, done}, 32'd1);

    // Randomized sweeps with ignored starts and occasional aborts.
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      gate_tt = 4'($urandom);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      cyc     = 0;
      while (!done && cyc < 100) begin
        if (busy && $urandom_range(0, 4) == 0) start = 1'b1;
        if ($urandom_range(0, 59) == 0) rst = 1'b1;
        tick();
        start = 1'b0;
        cyc++;
        if (rst) begin
          rst = 1'b0;
          break;
        end
      end
      if (cyc >= 100) chk("rand_timeout", 32'd0, 32'd1);
    end

    // Three-input NAND with SETTLE=1.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc    = 0;
    while (!done3 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("nand3_latency", cyc, 16);
    chk("nand3_pass", {31'd0, pass3}, 32'd1);
    chk("nand3_err", {28'd0, err3}, 32'd0);
    chk("nand3_ffv", {31'd0, ffv3}, 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
